dmem_responder: RTL and testbench

- Data-memory responder for the pipeline's MEM stage. It serves load/store requests issued by the core (the initiator side driven by the control unit's dmem_write and the MEM-stage operands) with a configurable fixed latency.
- Performs RV32I byte-lane steering for stores, and lane selection plus sign/zero extension for loads.
- Raises a stall to hold the pipeline while an access is outstanding.
- Holds its own word-addressed storage array.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_lane_align.sv | 88 ++++++++
 rtl/dmem_responder.sv | 127 ++++++++++++
 tb/tb_dmem_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared funct3/opcode constants, FSM state type and legality helper for dmem_responder
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LAT_W = 4;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    // Stores only have SB/SH/SW; loads additionally have the unsigned LBU/LHU forms.
    function automatic logic f3_legal(input logic write, input logic [2:0] f3);
        if (write) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - RV32I byte-lane steering, load extension and fault detection (DMEM_MISALIGN_TRAP_EN selects trap vs force-align)
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        write,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext,
    output logic        fault
);

    logic        is_half;
    logic        is_word;
    logic [1:0]  eff_lo;
    logic [31:0] shifted;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    always_comb begin
        is_half = (funct3[1:0] == 2'b01);
        is_word = (funct3[1:0] == 2'b10);
`ifdef DMEM_MISALIGN_TRAP_EN
        eff_lo = addr_lo;
        fault  = !f3_legal(write, funct3)
               || (is_half && addr_lo[0])
               || (is_word && (addr_lo != 2'b00));
`else
        // Misaligned halfword/word accesses drop the offending low bits and proceed.
        if (is_word) begin
            eff_lo = 2'b00;
        end else if (is_half) begin
            eff_lo = {addr_lo[1], 1'b0};
        end else begin
            eff_lo = addr_lo;
        end
        fault = !f3_legal(write, funct3);
`endif
    end

    always_comb begin
        byte_en     = 4'b0000;
        wdata_lanes = 32'h0;
        case (funct3[1:0])
            2'b00: begin
                byte_en     = 4'b0001 << eff_lo;
                wdata_lanes = {4{wdata[7:0]}};
            end
            2'b01: begin
                byte_en     = eff_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
            end
            2'b10: begin
                byte_en     = 4'b1111;
                wdata_lanes = wdata;
            end
            default: begin
                byte_en     = 4'b0000;
                wdata_lanes = 32'h0;
            end
        endcase
        if (fault || !write) begin
            byte_en = 4'b0000;
        end
    end

    always_comb begin
        shifted   = rword >> {eff_lo, 3'b000};
        sel_b     = shifted[7:0];
        sel_h     = eff_lo[1] ? rword[31:16] : rword[15:0];
        rdata_ext = 32'h0;
        case (funct3)
            F3_B:    rdata_ext = {{24{sel_b[7]}}, sel_b};
            F3_BU:   rdata_ext = {24'h0, sel_b};
            F3_H:    rdata_ext = {{16{sel_h[15]}}, sel_h};
            F3_HU:   rdata_ext = {16'h0, sel_h};
            F3_W:    rdata_ext = rword;
            default: rdata_ext = 32'h0;
        endcase
        if (fault || write) begin
            rdata_ext = 32'h0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency MEM-stage load/store responder with local word array and pipeline stall
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        stall_mem
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    dmem_state_t state;
    dmem_state_t state_next;

    logic [LAT_W-1:0]      cnt;
    logic [ADDR_WIDTH+1:0] lat_addr;
    logic [31:0]           lat_wdata;
    logic [2:0]            lat_funct3;
    logic                  lat_write;

    logic [31:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           rword;
    logic [3:0]            byte_en;
    logic [31:0]           wdata_lanes;
    logic [31:0]           rdata_ext;
    logic                  fault;
    logic                  accept;
    logic                  commit;

    // Address bits above the array simply alias.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

    assign word_idx = lat_addr[ADDR_WIDTH+1:2];
    assign rword    = mem[word_idx];
    assign accept   = (state == ST_IDLE) && req_valid;
    assign commit   = (state == ST_BUSY) && (cnt == '0);

    dmem_lane_align u_align (
        .write       (lat_write),
        .addr_lo     (lat_addr[1:0]),
        .funct3      (lat_funct3),
        .wdata       (lat_wdata),
        .rword       (rword),
        .byte_en     (byte_en),
        .wdata_lanes (wdata_lanes),
        .rdata_ext   (rdata_ext),
        .fault       (fault)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (req_valid) state_next = ST_BUSY;
            ST_BUSY: if (cnt == '0) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
        stall_mem = ((state == ST_IDLE) && req_valid) || (state == ST_BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            lat_addr   <= '0;
            lat_wdata  <= 32'h0;
            lat_funct3 <= 3'b000;
            lat_write  <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_fault  <= 1'b0;
        end else begin
            if (accept) begin
                cnt        <= LAT_W'(LATENCY - 1);
                lat_addr   <= req_addr[ADDR_WIDTH+1:0];
                lat_wdata  <= req_wdata;
                lat_funct3 <= req_funct3;
                lat_write  <= req_write;
            end else if (state == ST_BUSY) begin
                if (commit) begin
                    rsp_rdata <= rdata_ext;
                    rsp_fault <= fault;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    // Storage is never cleared; a reset landing on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder: vector table, reset/back-to-back sequences, random vs byte model
module tb_dmem_responder;

    localparam int LAT = 2;
    localparam int AW  = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        stall_mem;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mb [4096];

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rd;
        logic        exp_flt;
    } vec_t;

    vec_t tbl[$];

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .stall_mem  (stall_mem)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic void add(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] f3, input logic [31:0] erd, input logic eflt);
        vec_t v;
        v.w = w; v.addr = a; v.wdata = d; v.f3 = f3; v.exp_rd = erd; v.exp_flt = eflt;
        tbl.push_back(v);
    endfunction

    // Byte-level reference: size from funct3, alignment by modulo, array wraps at 4*2^AW bytes.
    task automatic model(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, output logic [31:0] rd, output logic flt);
        int size;
        int a;
        logic illegal;
        logic [31:0] v;
        size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        illegal = w ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        a       = int'(addr % 4096);
`ifdef DMEM_MISALIGN_TRAP_EN
        flt = illegal || ((a % size) != 0);
`else
        flt = illegal;
        a   = a - (a % size);
`endif
        rd = 32'h0;
        if (flt) return;
        if (w) begin
            for (int i = 0; i < size; i++) mb[a + i] = wdata[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(mb[a + i]) << (8 * i));
            if (!f3[2] && size < 4 && v[8*size-1]) begin
                for (int i = 8 * size; i < 32; i++) v[i] = 1'b1;
            end
            rd = v;
        end
    endtask

    task automatic access(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, output logic [31:0] rd, output logic flt);
        int g;
        int cycles;
        rd  = 32'h0;
        flt = 1'b0;
        @(negedge clk);
        req_write = w; req_addr = addr; req_wdata = wdata; req_funct3 = f3; req_valid = 1'b1;
        #1;
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk); #1; g++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        check("stall_on_req", 32'(stall_mem), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        cycles = 1;
        while (!rsp_valid && cycles < 40) begin
            check("stall_busy", 32'(stall_mem), 32'd1);
            @(negedge clk); #1; cycles++;
        end
        check("rsp_timeout", 32'(rsp_valid), 32'd1);
        if (!rsp_valid) return;
        check("latency", 32'(cycles), 32'(LAT + 1));
        check("stall_resp", 32'(stall_mem), 32'd0);
        check("ready_resp", 32'(req_ready), 32'd0);
        rd  = rsp_rdata;
        flt = rsp_fault;
        @(negedge clk); #1;
        check("rsp_one_pulse", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        flt;
        logic [31:0] erd;
        logic        eflt;
        logic [31:0] a;
        logic [2:0]  f3;
        logic        w;
        int          acc[$];
        int          resp_n;
        int          pulses;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_funct3 = 3'b000;
        repeat (3) @(negedge clk);
        #1;
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rdata", rsp_rdata, 32'h0);
        check("reset_fault", 32'(rsp_fault), 32'd0);
        check("reset_stall", 32'(stall_mem), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        add(1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 0);
        add(0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 0);
        add(0, 32'h13, 32'h0, 3'b000, 32'hFFFFFFDE, 0);
        add(0, 32'h13, 32'h0, 3'b100, 32'h000000DE, 0);
        add(0, 32'h10, 32'h0, 3'b001, 32'hFFFFBEEF, 0);
        add(0, 32'h12, 32'h0, 3'b101, 32'h0000DEAD, 0);
        add(1, 32'h11, 32'h000000AA, 3'b000, 32'h0, 0);
        add(0, 32'h10, 32'h0, 3'b010, 32'hDEADAAEF, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        add(0, 32'h12, 32'h0, 3'b010, 32'h0, 1);
        add(0, 32'h13, 32'h0, 3'b001, 32'h0, 1);
        add(1, 32'h11, 32'h00005566, 3'b001, 32'h0, 1);
        add(0, 32'h10, 32'h0, 3'b010, 32'hDEADAAEF, 0);
`else
        add(0, 32'h12, 32'h0, 3'b010, 32'hDEADAAEF, 0);
        add(0, 32'h13, 32'h0, 3'b001, 32'hFFFFDEAD, 0);
        add(1, 32'h11, 32'h00005566, 3'b001, 32'h0, 0);
        add(0, 32'h10, 32'h0, 3'b010, 32'hDEAD5566, 0);
`endif
        add(0, 32'h10, 32'h0, 3'b011, 32'h0, 1);
        add(1, 32'h10, 32'h0, 3'b100, 32'h0, 1);
        add(0, 32'h10, 32'h0, 3'b111, 32'h0, 1);
        add(1, 32'h1010, 32'h01020304, 3'b010, 32'h0, 0);
        add(0, 32'h10, 32'h0, 3'b010, 32'h01020304, 0);
        add(0, 32'h10, 32'h0, 3'b000, 32'h00000004, 0);
        add(0, 32'h12, 32'h0, 3'b001, 32'h00000102, 0);

        foreach (tbl[i]) begin
            access(tbl[i].w, tbl[i].addr, tbl[i].wdata, tbl[i].f3, rd, flt);
            check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("vec%0d_fault", i), 32'(flt), 32'(tbl[i].exp_flt));
        end

        // Reset during BUSY must drop the store.
        access(1, 32'h20, 32'hCAFEF00D, 3'b010, rd, flt);
        @(negedge clk);
        req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_funct3 = 3'b010; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        pulses = 0;
        for (int c = 0; c < LAT + 4; c++) begin
            if (rsp_valid) pulses++;
            @(negedge clk); #1;
        end
        check("rst_mid_no_rsp", 32'(pulses), 32'd0);
        access(0, 32'h20, 32'h0, 3'b010, rd, flt);
        check("rst_mid_old_data", rd, 32'hCAFEF00D);

        // req_valid held through RESP: refused there, accepted the cycle after.
        @(negedge clk);
        req_write = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; req_funct3 = 3'b010; req_valid = 1'b1;
        resp_n = 0;
        for (int cyc = 0; cyc < 4 * (LAT + 2) + 8; cyc++) begin
            #1;
            if (req_valid && req_ready) acc.push_back(cyc);
            if (rsp_valid) begin
                resp_n++;
                check("b2b_ready_in_resp", 32'(req_ready), 32'd0);
                check("b2b_stall_in_resp", 32'(stall_mem), 32'd0);
                check("b2b_rdata", rsp_rdata, 32'h01020304);
                if (resp_n == 2) req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b_accepts", 32'(acc.size()), 32'd2);
        check("b2b_responses", 32'(resp_n), 32'd2);
        if (acc.size() >= 2) check("b2b_spacing", 32'(acc[1] - acc[0]), 32'(LAT + 2));

        // Random traffic over a 64-byte window, with aliasing high bits.
        for (int i = 0; i < 16; i++) begin
            a = 32'h100 + 32'(4 * i);
            model(1, a, $urandom, 3'b010, erd, eflt);
            access(1, a, {mb[a + 3], mb[a + 2], mb[a + 1], mb[a]}, 3'b010, rd, flt);
        end
        for (int i = 0; i < 150; i++) begin
            logic [31:0] d;
            w = 1'($urandom_range(0, 1));
            a = 32'h100 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 3)) << 12);
            d = $urandom;
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (w) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            model(w, a, d, f3, erd, eflt);
            access(w, a, d, f3, rd, flt);
            check($sformatf("rand%0d_rdata w=%0d a=%h f3=%0d", i, w, a, f3), rd, erd);
            check($sformatf("rand%0d_fault", i), 32'(flt), 32'(eflt));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
